// File: rtl/matrix_scan_ctrl.sv
// Row scan sequencer and single-key arbiter for the 8x8 bicolour LED matrix.
// The row index advances every CLK_DIV cycles. The first BLANK_CYC cycles of
// each row dwell are blanked to suppress ghosting. The granted key and the
// octave switches are latched only on frame boundaries, so the column decoder
// always sees one consistent image per frame.
module matrix_scan_ctrl #(
  parameter int CLK_DIV   = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] btn_in,
  input  logic [1:0] sw_in,
  output logic [2:0] scan,
  output logic [7:0] row,
  output logic       blank,
  output logic [6:0] btn_out,
  output logic [1:0] sw_out,
  output logic       frame_start
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Arbiter states; state is kept as a plain named signal for probing
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HELD = 1'b1;

  logic [DIV_W-1:0] div_cnt;
  logic [0:0]       state;
  logic [0:0]       next_state;
  logic [6:0]       grant;
  logic [6:0]       next_grant;
  logic             frame_end;

  // Highest-priority set bit of a key vector (bit 6 = key 1 wins)
  function automatic logic [6:0] pick_highest(input logic [6:0] v);
    logic [6:0] r;
    r = '0;
    for (int i = 0; i < 7; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // Dwell counter and row index; scan wraps 7 -> 0 naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      scan    <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      scan    <= scan + 3'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Blanking window at the head of each row; BLANK_CYC=0 disables it entirely
  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign blank = 1'b0;
    end else begin : g_blank
      assign blank = rst || (div_cnt < DIV_W'(BLANK_CYC));
    end
  endgenerate

  assign row         = (blank || rst) ? 8'hFF : ~(8'h01 << scan);
  assign frame_start = (scan == 3'd0) && (div_cnt == '0) && !rst;
  assign frame_end   = (scan == 3'd7) && (div_cnt == DIV_LAST);

  // Sticky arbiter: a granted key keeps the grant until it is released
  always_comb begin
    next_state = state;
    next_grant = grant;
    case (state)
      IDLE: begin
        if (btn_in != 7'd0) begin
          next_grant = pick_highest(btn_in);
          next_state = HELD;
        end else begin
          next_grant = '0;
        end
      end
      HELD: begin
        if ((grant & btn_in) != 7'd0) begin
          next_grant = grant;
        end else if (btn_in != 7'd0) begin
          next_grant = pick_highest(btn_in);
        end else begin
          next_grant = '0;
          next_state = IDLE;
        end
      end
      default: begin
        next_grant = '0;
        next_state = IDLE;
      end
    endcase
  end

  // Arbiter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
    end else begin
      state <= next_state;
      grant <= next_grant;
    end
  end

  // Frame-boundary latch of key and octave, visible from the next frame_start
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_out <= '0;
      sw_out  <= 2'b01;
    end else if (frame_end) begin
      btn_out <= grant;
      sw_out  <= sw_in;
    end
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Bench for matrix_scan_ctrl with CLK_DIV=8. A second instance uses BLANK_CYC=0.
// Inputs change one delay after a rising edge (or on a falling edge); outputs
// are sampled on falling edges or one delay after a rising edge.
module tb_matrix_scan_ctrl;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HELD = 1'b1;

  logic       clk;
  logic       rst;
  logic [6:0] btn_in;
  logic [1:0] sw_in;
  logic [2:0] scan,  scan_nb;
  logic [7:0] row,   row_nb;
  logic       blank, blank_nb;
  logic [6:0] btn_out, btn_out_nb;
  logic [1:0] sw_out,  sw_out_nb;
  logic       frame_start, frame_start_nb;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] exp_q[$];
  logic [6:0] gnt_q[$];
  logic [0:0] st_q[$];

  matrix_scan_ctrl #(.CLK_DIV(8), .BLANK_CYC(2)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .sw_in(sw_in),
    .scan(scan), .row(row), .blank(blank),
    .btn_out(btn_out), .sw_out(sw_out), .frame_start(frame_start)
  );

  matrix_scan_ctrl #(.CLK_DIV(8), .BLANK_CYC(0)) dut_nb (
    .clk(clk), .rst(rst), .btn_in(btn_in), .sw_in(sw_in),
    .scan(scan_nb), .row(row_nb), .blank(blank_nb),
    .btn_out(btn_out_nb), .sw_out(sw_out_nb), .frame_start(frame_start_nb)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  function automatic logic [6:0] model_highest(input logic [6:0] v);
    logic [6:0] r;
    r = '0;
    for (int i = 6; i >= 0; i--) begin
      if (v[i] && r == 7'd0) r[i] = 1'b1;
    end
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; btn_in = 7'h7F; sw_in = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if ({scan, row, blank, btn_out, sw_out, frame_start} !== {3'd0, 8'hFF, 1'b1, 7'd0, 2'b01, 1'b0}) begin
        n_err++;
        $display("FAIL reset_values: got scan=%0d row=%h blank=%b btn_out=%b sw_out=%b fs=%b, expected scan=0 row=ff blank=1 btn_out=0000000 sw_out=01 fs=0",
                 scan, row, blank, btn_out, sw_out, frame_start);
      end
    end
    @(posedge clk); #1 rst = 1'b0; btn_in = 7'd0; sw_in = 2'b00;
    @(negedge clk);
    n_cmp++;
    if (frame_start !== 1'b1 || scan !== 3'd0) begin
      n_err++;
      $display("FAIL reset_release: got frame_start=%b scan=%0d, expected frame_start=1 scan=0", frame_start, scan);
    end
  endtask

  task automatic test_scan();
    logic [2:0] e_scan;
    logic       e_blank;
    logic [7:0] e_row;
    logic       e_fs;
    btn_in = 7'd0; sw_in = 2'b00;
    do_reset();
    for (int k = 0; k <= 64; k++) begin
      @(negedge clk);
      e_scan  = 3'((k / 8) % 8);
      e_blank = (k % 8) < 2;
      e_row   = ~(8'h01 << e_scan);
      if (e_blank) e_row = 8'hFF;
      e_fs    = (k % 64) == 0;
      n_cmp++;
      if ({scan, blank, row, frame_start} !== {e_scan, e_blank, e_row, e_fs}) begin
        n_err++;
        $display("FAIL scan_seq cyc %0d: got scan=%0d blank=%b row=%h fs=%b, expected scan=%0d blank=%b row=%h fs=%b",
                 k, scan, blank, row, frame_start, e_scan, e_blank, e_row, e_fs);
      end
    end
  endtask

  task automatic test_arbitration();
    logic [6:0] stim [6] = '{7'b0100000, 7'b1100000, 7'b1000000, 7'b0000000, 7'b0010001, 7'b0000000};
    logic [6:0] egnt [6] = '{7'b0100000, 7'b0100000, 7'b1000000, 7'b0000000, 7'b0010000, 7'b0000000};
    logic [0:0] est  [6] = '{S_HELD, S_HELD, S_HELD, S_IDLE, S_HELD, S_IDLE};
    logic [6:0] g;
    logic [0:0] s;
    btn_in = 7'd0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      btn_in = stim[i];
      gnt_q.push_back(egnt[i]);
      st_q.push_back(est[i]);
      @(posedge clk); #1;
      g = gnt_q.pop_front();
      s = st_q.pop_front();
      n_cmp++;
      if (dut.grant !== g || dut.state !== s) begin
        n_err++;
        $display("FAIL arb_step %0d: got grant=%b state=%b, expected grant=%b state=%b", i, dut.grant, dut.state, g, s);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] v;
    logic [6:0] mg;
    logic [0:0] ms;
    logic [6:0] g;
    int r, idx;
    v = '0; mg = '0; ms = S_IDLE;
    btn_in = 7'd0;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 3);
      if (r == 0) v = 7'($urandom_range(0, 127));
      else if (r == 1) begin
        idx = $urandom_range(0, 6);
        v[idx] = ~v[idx];
      end else if (r == 2 && $urandom_range(0, 3) == 0) v = '0;
      btn_in = v;
      if (ms == S_IDLE) begin
        if (v != 7'd0) begin mg = model_highest(v); ms = S_HELD; end
        else mg = '0;
      end else if ((mg & v) == 7'd0) begin
        if (v != 7'd0) mg = model_highest(v);
        else begin mg = '0; ms = S_IDLE; end
      end
      gnt_q.push_back(mg);
      @(posedge clk); #1;
      g = gnt_q.pop_front();
      n_cmp++;
      if (dut.grant !== g) begin
        n_err++;
        $display("FAIL arb_random %0d: btn=%b got grant=%b, expected %b", i, v, dut.grant, g);
      end
    end
    btn_in = 7'd0;
  endtask

  task automatic test_frame_latch();
    logic [8:0] e;
    btn_in = 7'd0; sw_in = 2'b00;
    do_reset();
    for (int k = 0; k <= 130; k++) begin
      @(negedge clk);
      if (k >= 1 && k <= 63) begin
        n_cmp++;
        if (btn_out !== 7'd0 || sw_out !== 2'b01) begin
          n_err++;
          $display("FAIL latch_hold1 cyc %0d: got btn_out=%b sw_out=%b, expected 0000000/01", k, btn_out, sw_out);
        end
      end
      if (k >= 65 && k <= 127) begin
        n_cmp++;
        if (btn_out !== 7'b0000100 || sw_out !== 2'b11) begin
          n_err++;
          $display("FAIL latch_hold2 cyc %0d: got btn_out=%b sw_out=%b, expected 0000100/11", k, btn_out, sw_out);
        end
      end
      if (k > 0 && frame_start === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL latch_frame cyc %0d: unexpected frame_start, got 1 expected 0", k);
        end else begin
          e = exp_q.pop_front();
          if ({btn_out, sw_out} !== e || (k % 64) != 0) begin
            n_err++;
            $display("FAIL latch_frame cyc %0d: got btn_out=%b sw_out=%b, expected %b/%b at a multiple of 64",
                     k, btn_out, sw_out, e[8:2], e[1:0]);
          end
        end
      end
      if (k == 20) begin
        btn_in = 7'b0000100; sw_in = 2'b11;
        exp_q.push_back({7'b0000100, 2'b11});
      end
      if (k == 70) begin
        btn_in = 7'd0;
        exp_q.push_back({7'b0000000, 2'b11});
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL latch_drain: got %0d pending frames, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    btn_in = 7'b0000100; sw_in = 2'b10;
    do_reset();
    for (int k = 0; k <= 101; k++) begin
      @(negedge clk);
      if (k == 64) begin
        n_cmp++;
        if (btn_out !== 7'b0000100 || sw_out !== 2'b10) begin
          n_err++;
          $display("FAIL mid_pre: got btn_out=%b sw_out=%b, expected 0000100/10", btn_out, sw_out);
        end
      end
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (scan !== 3'd4 || row !== 8'hFF || frame_start !== 1'b0) begin
      n_err++;
      $display("FAIL mid_assert: got scan=%0d row=%h fs=%b, expected scan=4 row=ff fs=0", scan, row, frame_start);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({scan, row, btn_out, sw_out, frame_start} !== {3'd0, 8'hFF, 7'd0, 2'b01, 1'b1}) begin
      n_err++;
      $display("FAIL mid_after: got scan=%0d row=%h btn_out=%b sw_out=%b fs=%b, expected scan=0 row=ff btn_out=0000000 sw_out=01 fs=1",
               scan, row, btn_out, sw_out, frame_start);
    end
    btn_in = 7'd0;
  endtask

  task automatic test_no_blank();
    logic [7:0] e_row;
    btn_in = 7'd0;
    do_reset();
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      e_row = ~(8'h01 << (k / 8));
      n_cmp++;
      if (blank_nb !== 1'b0 || row_nb !== e_row) begin
        n_err++;
        $display("FAIL no_blank cyc %0d: got blank=%b row=%h, expected blank=0 row=%h", k, blank_nb, row_nb, e_row);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_arbitration();
    test_back_to_back();
    test_frame_latch();
    test_reset_mid();
    test_no_blank();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
